alu_sweep_chk: RTL and testbench

ALU_SWEEP_CHK -- requirements
Module: alu_sweep_chk

---
 rtl/alu_sweep_chk.sv | 143 ++++++++++++++
 tb/tb_alu_sweep_chk.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_chk.sv
// ALU sweep checker: drives every operand pair {idx, ~idx} through an external ALU and counts wrong or missing results.
// Build option ALU_CHK_ALLOPS_EN sweeps all eight opcodes instead of only op_sel.
module alu_sweep_chk #(
  parameter int W       = 5,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op_sel,
  output logic           req_valid,
  input  logic           req_ready,
  output logic [W-1:0]   req_a,
  output logic [W-1:0]   req_b,
  output logic [2:0]     req_op,
  input  logic           rsp_valid,
  input  logic [W:0]     rsp_data,
  output logic           busy,
  output logic           done,
  output logic [W+3:0]   err_cnt,
  output logic [W+2:0]   first_fail,
  output logic [1:0]     state_dbg
);

  // Request handshake: a request transfers on a cycle where req_valid && req_ready;
  // req_a/req_b/req_op stay constant while req_valid is high and ready is low.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, FIN = 2'd3} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   idx, idx_nx, idx_inv;
  logic [2:0]     op, op_nx;
  logic [7:0]     timer, timer_nx;
  logic [W+3:0]   err_nx;
  logic [W+2:0]   ff_nx;
  logic [W:0]     exp_val;
  logic           last_tx, tmo, fail;

  assign idx_inv = ~idx;

  always_comb begin
    exp_val = '0;
    case (op)
      3'd0: exp_val = {1'b0, idx} + {1'b0, idx_inv};
      3'd1: exp_val = {1'b0, idx} - {1'b0, idx_inv};
      3'd2: exp_val = {1'b0, idx ^ idx_inv};
      3'd3: exp_val = {1'b0, idx & idx_inv};
      3'd4: exp_val = {1'b0, idx | idx_inv};
      3'd5: exp_val = {1'b0, ~(idx ^ idx_inv)};
      3'd6: exp_val = {1'b0, ~(idx & idx_inv)};
      default: exp_val = {1'b0, ~(idx | idx_inv)};
    endcase
  end

`ifdef ALU_CHK_ALLOPS_EN
  assign last_tx = (op == 3'd7) && (idx == '1);
`else
  assign last_tx = (idx == '1);
`endif

  // A response arriving on the final timer cycle takes priority over the timeout.
  assign tmo  = (timer == 8'(TIMEOUT - 1));
  assign fail = rsp_valid ? (rsp_data != exp_val) : tmo;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    op_nx    = op;
    timer_nx = timer;
    err_nx   = err_cnt;
    ff_nx    = first_fail;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          idx_nx   = '0;
          timer_nx = '0;
          err_nx   = '0;
          ff_nx    = '1;
`ifdef ALU_CHK_ALLOPS_EN
          op_nx    = 3'd0;
`else
          op_nx    = op_sel;
`endif
        end
      end
      ISSUE: begin
        if (req_ready) begin
          state_nx = WAIT;
          timer_nx = '0;
        end
      end
      WAIT: begin
        if (rsp_valid || tmo) begin
          if (fail) begin
            err_nx = err_cnt + 1'b1;
            if (first_fail == '1) ff_nx = {op, idx};
          end
          if (last_tx) begin
            state_nx = FIN;
          end else begin
            state_nx = ISSUE;
            idx_nx   = idx + 1'b1;
`ifdef ALU_CHK_ALLOPS_EN
            if (idx == '1) op_nx = op + 3'd1;
`endif
          end
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      op         <= '0;
      timer      <= '0;
      err_cnt    <= '0;
      first_fail <= '1;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      op         <= op_nx;
      timer      <= timer_nx;
      err_cnt    <= err_nx;
      first_fail <= ff_nx;
    end
  end

  always_comb begin
    req_valid = (state == ISSUE);
    req_a     = req_valid ? idx : '0;
    req_b     = req_valid ? idx_inv : '0;
    req_op    = req_valid ? op : 3'd0;
    busy      = (state == ISSUE) || (state == WAIT);
    done      = (state == FIN);
    state_dbg = state;
  end

endmodule

// File: tb/tb_alu_sweep_chk.sv
// Directed bench for alu_sweep_chk with a behavioural ALU responder (latency, silence, corruption, ready stalls).
module tb_alu_sweep_chk;

`ifdef ALU_CHK_ALLOPS_EN
  localparam int N_TX = 256;
`else
  localparam int N_TX = 32;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] op_sel;
  logic       req_valid, req_ready;
  logic [4:0] req_a, req_b;
  logic [2:0] req_op;
  logic       rsp_valid;
  logic [5:0] rsp_data;
  logic       busy, done;
  logic [8:0] err_cnt;
  logic [7:0] first_fail;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // responder controls and bookkeeping
  int         lat = 0;
  bit         silent = 0;
  bit         corrupt = 0;
  logic [2:0] c_op = 3'd0;
  logic [4:0] c_idx = 5'd0;
  int         stall_at = -1;
  int         stall_left = 0;
  bit         pend = 0;
  int         wait_c = 0;
  logic [4:0] cap_a, cap_b;
  logic [2:0] cap_op;
  int         hs_cnt = 0;
  int         done_cnt = 0;
  logic [2:0] exp_sel = 3'd0;

  always #5 clk = ~clk;

  alu_sweep_chk dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .done(done),
    .err_cnt(err_cnt), .first_fail(first_fail), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] alu_ref(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a ^ b};
      3'd3: return {1'b0, a & b};
      3'd4: return {1'b0, a | b};
      3'd5: return {1'b0, ~(a ^ b)};
      3'd6: return {1'b0, ~(a & b)};
      default: return {1'b0, ~(a | b)};
    endcase
  endfunction

  function automatic logic [2:0] exp_op(input int n);
`ifdef ALU_CHK_ALLOPS_EN
    return 3'(n / 32);
`else
    return exp_sel;
`endif
  endfunction

  // ALU responder: everything happens on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (pend) begin
      if (wait_c == 0) begin
        pend = 0;
        if (!silent) begin
          rsp_valid = 1'b1;
          rsp_data  = (corrupt && cap_op == c_op && cap_a == c_idx) ? 6'd0 : alu_ref(cap_a, cap_b, cap_op);
        end
      end else begin
        wait_c--;
      end
    end
    if (req_valid && hs_cnt == stall_at && stall_left > 0) begin
      req_ready = 1'b0;
      stall_left--;
      chk("stall_a", 32'(req_a), 32'd4);
      chk("stall_b", 32'(req_b), 32'd27);
    end else begin
      req_ready = 1'b1;
    end
    if (req_valid && req_ready) begin
      chk("hs_a", 32'(req_a), 32'(hs_cnt % 32));
      chk("hs_b", 32'(req_b), 32'(31 - (hs_cnt % 32)));
      chk("hs_op", 32'(req_op), 32'(exp_op(hs_cnt)));
      chk("hs_busy", 32'(busy), 32'd1);
      hs_cnt++;
      pend   = 1;
      wait_c = lat;
      cap_a  = req_a;
      cap_b  = req_b;
      cap_op = req_op;
    end
    if (done) begin
      done_cnt++;
      chk("fin_busy", 32'(busy), 32'd0);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(req_valid), 32'd0);
    chk({tag, "_a"}, 32'(req_a), 32'd0);
    chk({tag, "_b"}, 32'(req_b), 32'd0);
    chk({tag, "_op"}, 32'(req_op), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    chk({tag, "_ff"}, 32'(first_fail), 32'hFF);
    chk({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic wait_done(input int limit, inout int n);
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $error("FAIL done_timeout obs=0 exp=1");
    end
    @(negedge clk);
  endtask

  // start pulse; n counts falling edges from the edge after start was sampled to the one showing done
  task automatic run_sweep(input logic [2:0] sel, output int n);
    op_sel   = sel;
    exp_sel  = sel;
    hs_cnt   = 0;
    done_cnt = 0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    wait_done(20000, n);
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b0; start = 1'b0; op_sel = 3'd0; req_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // correct zero-latency ALU, add: every result is 31
    run_sweep(3'd0, n);
    chk("add_cycles", 32'(n), 32'(2 * N_TX + 1));
    chk("add_hs", 32'(hs_cnt), 32'(N_TX));
    chk("add_err", 32'(err_cnt), 32'd0);
    chk("add_ff", 32'(first_fail), 32'hFF);
    chk("add_done", 32'(done_cnt), 32'd1);

    // one corrupted result for sub at idx 7
    corrupt = 1; c_op = 3'd1; c_idx = 5'd7;
    run_sweep(3'd1, n);
    chk("sub_err", 32'(err_cnt), 32'd1);
    chk("sub_ff", 32'(first_fail), 32'h27);
    repeat (5) @(negedge clk);
    chk("sub_hold_err", 32'(err_cnt), 32'd1);
    chk("sub_hold_ff", 32'(first_fail), 32'h27);
    corrupt = 0;

    // silent ALU: every transaction times out
    silent = 1;
    run_sweep(3'd2, n);
    chk("tmo_cycles", 32'(n), 32'(16 * N_TX + 1));
    chk("tmo_err", 32'(err_cnt), 32'(N_TX));
`ifdef ALU_CHK_ALLOPS_EN
    chk("tmo_ff", 32'(first_fail), 32'h00);
`else
    chk("tmo_ff", 32'(first_fail), 32'h40);
`endif
    chk("tmo_done", 32'(done_cnt), 32'd1);
    silent = 0;

    // response on the last timer cycle wins
    lat = 14;
    run_sweep(3'd5, n);
    chk("edge_cycles", 32'(n), 32'(16 * N_TX + 1));
    chk("edge_err", 32'(err_cnt), 32'd0);
    chk("edge_ff", 32'(first_fail), 32'hFF);

    // one cycle too late: timeout, and the late response lands in ISSUE and is ignored
    lat = 15;
    run_sweep(3'd6, n);
    chk("late_err", 32'(err_cnt), 32'(N_TX));
`ifdef ALU_CHK_ALLOPS_EN
    chk("late_ff", 32'(first_fail), 32'h00);
`else
    chk("late_ff", 32'(first_fail), 32'hC0);
`endif
    chk("late_hs", 32'(hs_cnt), 32'(N_TX));
    lat = 0;
    repeat (20) @(negedge clk);

    // ready held low for 10 cycles at idx 4
    stall_at = 4; stall_left = 10;
    run_sweep(3'd0, n);
    chk("stall_cycles", 32'(n), 32'(2 * N_TX + 11));
    chk("stall_hs", 32'(hs_cnt), 32'(N_TX));
    chk("stall_err", 32'(err_cnt), 32'd0);
    chk("stall_used", 32'(stall_left), 32'd0);
    stall_at = -1;

    // start during a sweep is ignored; op_sel is latched
    op_sel = 3'd4; exp_sel = 3'd4; hs_cnt = 0; done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    op_sel = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    wait_done(2000, n);
    chk("restart_hs", 32'(hs_cnt), 32'(N_TX));
    chk("restart_err", 32'(err_cnt), 32'd0);
    chk("restart_done", 32'(done_cnt), 32'd1);

    // reset while waiting on idx 12; the pending (wrong) response arrives after reset
    lat = 5; corrupt = 1; c_op = 3'd0; c_idx = 5'd12;
    op_sel = 3'd0; exp_sel = 3'd0; hs_cnt = 0; done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (hs_cnt < 13 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("rst_pre_state", 32'(state_dbg), 32'd2);
    chk("rst_pre_a", 32'(cap_a), 32'd12);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_late_err", 32'(err_cnt), 32'd0);
    chk("midrst_late_ff", 32'(first_fail), 32'hFF);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_idle", 32'(state_dbg), 32'd0);
    lat = 0; corrupt = 0;

    run_sweep(3'd0, n);
    chk("post_cycles", 32'(n), 32'(2 * N_TX + 1));
    chk("post_hs", 32'(hs_cnt), 32'(N_TX));
    chk("post_err", 32'(err_cnt), 32'd0);
    chk("post_ff", 32'(first_fail), 32'hFF);
    chk("post_done", 32'(done_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
